// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: program-memory request/response, decode handshake and redirect.
// "master" is the fetch unit side, "slave" is the memory/core side.
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [31:0]           mem_rsp_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: credit-limited program-memory requests, in-order prefetch FIFO
// and redirect flush that discards every response still owed to the old path.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_fetch_unit_if.master     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic                  active;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [31:0]           data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

    logic                  req_fire;
    logic                  push;
    logic                  pop;
    logic [CW:0]           in_use;
    logic [ADDR_WIDTH-1:0] redirect_base;
    logic [CW-1:0]         outstanding_nxt;
    logic [CW-1:0]         drop_nxt;
    logic [CW-1:0]         count_nxt;

    // Slots already promised (live in-flight requests plus buffered words) bound the request rate,
    // so every accepted response is guaranteed room without any backpressure path.
    assign in_use            = {1'b0, outstanding} - {1'b0, drop} + {1'b0, count};
    assign bus.mem_req_valid = active && (in_use < DEPTH_C);
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.instr_valid   = (count != '0);
    assign bus.instr_data    = data_q[rd_ptr];
    assign bus.instr_pc      = pc_q[rd_ptr];

    assign req_fire      = bus.mem_req_valid && bus.mem_req_ready;
    assign push          = bus.mem_rsp_valid && (drop == '0) && !bus.redirect_valid;
    assign pop           = bus.instr_valid && bus.instr_ready;
    assign redirect_base = bus.redirect_pc & ~ADDR_WIDTH'(3);

    always_comb begin
        outstanding_nxt = outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);
        drop_nxt        = drop;
        count_nxt       = count + CW'(push) - CW'(pop);
        if (bus.redirect_valid) begin
            drop_nxt  = outstanding_nxt;
            count_nxt = '0;
        end else if (bus.mem_rsp_valid && (drop != '0)) begin
            drop_nxt = drop - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active      <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            active      <= 1'b1;
            outstanding <= outstanding_nxt;
            drop        <= drop_nxt;
            count       <= count_nxt;
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                end
                if (push) begin
                    data_q[wr_ptr] <= bus.mem_rsp_data;
                    pc_q[wr_ptr]   <= rsp_pc;
                    wr_ptr         <= wr_ptr + PW'(1);
                    rsp_pc         <= rsp_pc + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order program memory model.
module tb_instr_fetch_unit;
    logic clk;
    logic reset;

    instr_fetch_unit_if #(.ADDR_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    pend_t pending[$];
    int    cyc = 0;
    int    memLatency = 1;
    int    reqCount = 0;
    int    assertCount = 0;
    int    failCount = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: five ALU-immediate words at the start, address-tagged words elsewhere.
    function automatic logic [31:0] expWord(input logic [31:0] addr);
        case (addr)
            32'h00: return 32'h0010_0093;
            32'h04: return 32'h0020_F113;
            32'h08: return 32'h0030_E193;
            32'h0C: return 32'h0040_8213;
            32'h10: return 32'h0050_F293;
            default: return 32'hA000_0000 | addr;
        endcase
    endfunction

    // Memory accepts a request on the cycle's settled handshake and answers memLatency cycles later.
    always @(negedge clk) begin
        if (!reset) begin
            pending.delete();
        end else if (bus.mem_req_valid && bus.mem_req_ready) begin
            pending.push_back('{due: cyc + memLatency, addr: bus.mem_req_addr});
            reqCount++;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        if (reset && pending.size() > 0 && pending[0].due <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = expWord(pending[0].addr);
            void'(pending.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redirValid, input logic [31:0] redirPc);
        bus.instr_ready    = ready;
        bus.redirect_valid = redirValid;
        bus.redirect_pc    = redirPc;
    endtask

    task automatic waitValid(input string tag, input int budget);
        int n = 0;
        while (!bus.instr_valid && n < budget) begin
            tick();
            n++;
        end
        if (!bus.instr_valid) checkOutput(tag, 32'h0, 32'h1);
    endtask

    task automatic doReset(input logic ready, input int latency);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        bus.mem_req_ready = 1'b1;
        repeat (3) tick();
        memLatency = latency;
        applyStimulus(ready, 1'b0, 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        int startCount;
        reset = 1'b0;
        bus.mem_req_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset values, then straight-line fetch with a 1-cycle memory
        repeat (3) tick();
        checkOutput("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
        checkOutput("rst_req_addr", bus.mem_req_addr, 32'h0);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("rst_instr_data", bus.instr_data, 32'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
        memLatency = 1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("first_req_valid", 32'(bus.mem_req_valid), 32'h1);
        checkOutput("first_req_addr", bus.mem_req_addr, 32'h0);
        tick();
        checkOutput("second_req_addr", bus.mem_req_addr, 32'h4);
        checkOutput("first_valid_latency", 32'(bus.instr_valid), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("line_valid_%0d", i), 32'(bus.instr_valid), 32'h1);
            checkOutput($sformatf("line_pc_%0d", i), bus.instr_pc, 32'(4 * i));
            checkOutput($sformatf("line_data_%0d", i), bus.instr_data, expWord(32'(4 * i)));
            tick();
        end

        // Backpressure: credits cap requests at DEPTH, one pop frees exactly one
        doReset(1'b0, 1);
        startCount = reqCount;
        repeat (10) tick();
        checkOutput("bp_req_count", 32'(reqCount - startCount), 32'd4);
        checkOutput("bp_req_stalled", 32'(bus.mem_req_valid), 32'h0);
        checkOutput("bp_head_valid", 32'(bus.instr_valid), 32'h1);
        checkOutput("bp_head_pc", bus.instr_pc, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (6) tick();
        checkOutput("bp_req_count_pop", 32'(reqCount - startCount), 32'd5);
        checkOutput("bp_req_stalled_pop", 32'(bus.mem_req_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp_drain_valid_%0d", i), 32'(bus.instr_valid), 32'h1);
            checkOutput($sformatf("bp_drain_pc_%0d", i), bus.instr_pc, 32'(4 + 4 * i));
            checkOutput($sformatf("bp_drain_data_%0d", i), bus.instr_data, expWord(32'(4 + 4 * i)));
            tick();
        end

        // Redirect with two requests in flight on a 3-cycle memory
        doReset(1'b1, 3);
        tick();
        tick();
        tick();
        bus.mem_req_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h40);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        bus.mem_req_ready = 1'b1;
        checkOutput("redir_req_addr", bus.mem_req_addr, 32'h40);
        checkOutput("redir_req_valid", 32'(bus.mem_req_valid), 32'h1);
        checkOutput("redir_instr_valid", 32'(bus.instr_valid), 32'h0);
        waitValid("redir_timeout", 20);
        checkOutput("redir_pc0", bus.instr_pc, 32'h40);
        checkOutput("redir_data0", bus.instr_data, expWord(32'h40));
        tick();
        checkOutput("redir_valid1", 32'(bus.instr_valid), 32'h1);
        checkOutput("redir_pc1", bus.instr_pc, 32'h44);
        checkOutput("redir_data1", bus.instr_data, expWord(32'h44));

        // Redirect, response, pop and request acceptance in one cycle
        doReset(1'b0, 1);
        tick();
        tick();
        tick();
        checkOutput("corner_head_valid", 32'(bus.instr_valid), 32'h1);
        checkOutput("corner_head_pc", bus.instr_pc, 32'h0);
        checkOutput("corner_head_data", bus.instr_data, expWord(32'h0));
        checkOutput("corner_req_valid", 32'(bus.mem_req_valid), 32'h1);
        applyStimulus(1'b1, 1'b1, 32'h103);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("corner_req_addr", bus.mem_req_addr, 32'h100);
        checkOutput("corner_req_valid_after", 32'(bus.mem_req_valid), 32'h1);
        checkOutput("corner_flushed", 32'(bus.instr_valid), 32'h0);
        tick();
        checkOutput("corner_late_dropped", 32'(bus.instr_valid), 32'h0);
        tick();
        checkOutput("corner_new_valid", 32'(bus.instr_valid), 32'h1);
        checkOutput("corner_new_pc", bus.instr_pc, 32'h100);
        checkOutput("corner_new_data", bus.instr_data, expWord(32'h100));

        // Asynchronous reset with three buffered words
        doReset(1'b0, 1);
        repeat (5) tick();
        checkOutput("mid_valid_before", 32'(bus.instr_valid), 32'h1);
        checkOutput("mid_pc_before", bus.instr_pc, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid_async_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("mid_async_req", 32'(bus.mem_req_valid), 32'h0);
        checkOutput("mid_async_addr", bus.mem_req_addr, 32'h0);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("mid_restart_valid", 32'(bus.mem_req_valid), 32'h1);
        checkOutput("mid_restart_addr", bus.mem_req_addr, 32'h0);
        waitValid("mid_restart_timeout", 10);
        checkOutput("mid_restart_pc", bus.instr_pc, 32'h0);
        checkOutput("mid_restart_data", bus.instr_data, expWord(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetch stage directly upstream of the single-cycle CPU core.
- Reads instruction words from program memory over a request/response interface and buffers them in a small prefetch FIFO.
- Hands instructions and their PCs to the core's decode with a valid/ready handshake.
- Discards in-flight and buffered words on a control-flow redirect (branch/jump) from the core.

## Interface
- ADDR_WIDTH, 32, width of PC and memory address
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2; also the credit limit

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- mem_req_valid  out  1  fetch request present
- mem_req_ready  in  1  memory accepts request this cycle
- mem_req_addr  out  ADDR_WIDTH  word-aligned fetch address
- mem_rsp_valid  in  1  response word present (no backpressure)
- mem_rsp_data  in  32  instruction word
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  core consumes head this cycle
- instr_data  out  32  instruction at FIFO head
- instr_pc  out  ADDR_WIDTH  PC of instr_data
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_WIDTH  new PC; bits [1:0] ignored (forced 0)

## Operation
- State:
  - fetch_pc: next request address.
  - rsp_pc: PC of next accepted response.
  - outstanding: accepted but unanswered requests.
  - drop: responses still to be discarded.
  - FIFO of {data, pc}, count 0..DEPTH.
- Credit rule: mem_req_valid = (outstanding − drop + count) < DEPTH.
  - Every accepted response is guaranteed a FIFO slot.
  - mem_req_valid never depends combinationally on redirect_valid, mem_rsp_*, or instr_ready.
- Request handshake: mem_req_valid && mem_req_ready → outstanding+1, fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH).
- Memory contract: responses return in order, at least 1 cycle after acceptance.
- Each mem_rsp_valid decrements outstanding, then:
  - drop > 0: drop−1, word discarded.
  - otherwise: push {mem_rsp_data, rsp_pc}, rsp_pc += 4.
- Consume: instr_valid && instr_ready pops the head.
- Redirect (redirect_valid=1):
  - fetch_pc and rsp_pc ← {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - FIFO count ← 0.
  - drop ← all requests outstanding after this cycle's updates, including one accepted this same cycle.
- Simultaneous events in a redirect cycle:
  - A response arriving this cycle is discarded.
  - A pop this cycle completes; the core keeps that instruction.
  - A request accepted this cycle targets the old fetch_pc and is dropped.
- Response and pop in the same cycle with FIFO full: legal (credit rule prevents overflow).
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests are a system-level violation; memory is reset together with this block.

## Timing
- Reset values:
  - mem_req_valid = 0, mem_req_addr = RESET_PC.
  - instr_valid = 0, instr_data = 0, instr_pc = 0.
  - Counters zero, drop = 0.
- First request: mem_req_valid = 1 in the first clk cycle after reset deasserts, addr = RESET_PC.
- Sustained throughput: one request per cycle while credits remain.
- Response to instr_valid: response in cycle M → instr_valid at M+1 (registered FIFO).
  - With 1-cycle memory, first instr_valid is 2 cycles after the first request is accepted.
- Redirect asserted in cycle N:
  - mem_req_addr = redirect_pc from N+1.
  - instr_valid = 0 in N+1.
  - First new instruction no earlier than N+3.
- instr_data / instr_pc stable while instr_valid && !instr_ready.

## Test plan
- Reset: hold reset=0 for 3 cycles → all outputs at reset values; release → mem_req_valid=1, mem_req_addr=0x0 on the next edge.
- Straight-line: 1-cycle memory preloaded with five addi/andi/ori words, instr_ready=1 → instr_pc 0x0,0x4,0x8,0xC,0x10 one per cycle, instr_data matches each word.
- Backpressure: instr_ready=0 → exactly DEPTH=4 requests issued, then mem_req_valid=0; one pop → exactly one more request; no word lost or duplicated.
- Redirect with 2 outstanding requests and 3-cycle memory latency: redirect_pc=0x40 → both late responses discarded; next instr_pc=0x40, then 0x44.
- Corner cycle: redirect, response, pop, and request acceptance all in one cycle; redirect_pc=0x103 → popped word delivered, response and accepted request dropped, next fetch addr=0x100.
- Reset mid-stream with FIFO holding 3 entries → instr_valid=0 immediately (asynchronous); fetch restarts at RESET_PC.
